bs_sub16: RTL

Bit-serial 16-bit subtractor with a start/done handshake. It computes a − b − bin over N clock cycles, one bit per cycle, LSB first, using a single borrow flop. It is the inverse-operation companion to the 16-bit ripple-carry adder in the arithmetic library, trading latency for area, and it gives the same carry/borrow semantics so results can be cross-checked against the adder.

---
 rtl/bs_sub16.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bs_sub16.sv
// bs_sub16: bit-serial N-bit subtractor (a - b - bin), LSB first, single borrow flop.
// A start/done handshake frames each operation. Results are registered and held
// between completions.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one difference bit per cycle, N cycles in total
// DONE  | one-cycle done pulse; start here chains straight into RUN
module bs_sub16 #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [N-1:0]   sa, sb, sr;
    logic           borrow;
    logic           amsb, bmsb;
    logic [CW-1:0]  cnt;
    logic           x, borrow_nx, last, accept;

    // Per-bit difference and borrow for the bit currently at the LSB.
    assign x         = sa[0] ^ sb[0] ^ borrow;
    assign borrow_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
    assign last      = (cnt == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; accept marks the edge that samples the operands.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand load, serial shift and result capture on the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            borrow <= 1'b0;
            amsb   <= 1'b0;
            bmsb   <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            amsb   <= a[N-1];
            bmsb   <= b[N-1];
            cnt    <= '0;
        end else if (state == RUN) begin
            sa     <= {1'b0, sa[N-1:1]};
            sb     <= {1'b0, sb[N-1:1]};
            sr     <= {x, sr[N-1:1]};
            borrow <= borrow_nx;
            cnt    <= cnt + 1'b1;
            if (last) begin
                // x is the final MSB of the difference, so it stands in for d[N-1].
                d    <= {x, sr[N-1:1]};
                bout <= borrow_nx;
                ovf  <= (amsb ^ bmsb) & (amsb ^ x);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
